z8_mem_responder: RTL and testbench

Z8_MEM_RESPONDER -- requirements
Module: z8_mem_responder

---
 rtl/instruction_set_pkg.sv | 21 ++
 rtl/z8_mem_responder_ram.sv | 27 ++
 rtl/z8_mem_responder.sv | 122 ++++++++++++
 tb/tb_z8_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_set_pkg.sv
// Shared instruction-set types: memory request opcodes and responder FSM states.
package instruction_set_pkg;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } MEM_OPS_T;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } RESP_STATE_T;

  // True for opcodes that touch memory and produce a response; anything else acts as NOP.
  function automatic logic is_mem_access(input MEM_OPS_T op);
    return (op == MEM_READ) || (op == MEM_WRITE);
  endfunction

endpackage

// File: rtl/z8_mem_responder_ram.sv
// Single-port storage: synchronous write, registered read, no reset.
module z8_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Access port: write when enabled, read data registered on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/z8_mem_responder.sv
// Memory responder: accepts one READ/WRITE at a time, waits WAIT_STATES cycles,
// then holds a response until the core consumes it.
module z8_mem_responder
  import instruction_set_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  MEM_OPS_T          req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned CntW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned RamAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  RESP_STATE_T       state_q;
  logic [CntW-1:0]   cnt_q;
  MEM_OPS_T          op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_rd_q;

  logic              acc_rw;
  logic              go_resp;
  MEM_OPS_T          cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              in_range;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;

  // Request path is taken straight from the inputs while idle so a zero-wait
  // transaction can hit the array on the edge right after its accept.
  always_comb begin
    req_ready = (state_q == R_IDLE);
    acc_rw    = req_ready && req_valid && is_mem_access(req_op);
    go_resp   = ((state_q == R_IDLE) && acc_rw && (WAIT_STATES == 0)) ||
                ((state_q == R_WAIT) && (cnt_q <= CntW'(1)));
    cur_op    = (state_q == R_IDLE) ? req_op    : op_q;
    cur_addr  = (state_q == R_IDLE) ? req_addr  : addr_q;
    cur_wdata = (state_q == R_IDLE) ? req_wdata : wdata_q;
    in_range  = 32'(cur_addr) < DEPTH;
    // Gating with rst aborts a write whose commit edge coincides with reset.
    ram_en    = go_resp && in_range && !rst;
    rsp_valid = rsp_valid_q;
    rsp_err   = rsp_err_q;
    rsp_rdata = rsp_rd_q ? ram_rdata : '0;
  end

  // Responder FSM with registered response flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= R_IDLE;
      cnt_q       <= '0;
      op_q        <= MEM_NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      unique case (state_q)
        R_IDLE: begin
          if (acc_rw) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (!go_resp) begin
              state_q <= R_WAIT;
              cnt_q   <= CntW'(WAIT_STATES);
            end
          end
        end
        R_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
        end
        R_RESP: begin
          if (rsp_ready) begin
            state_q     <= R_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
          end
        end
        default: state_q <= R_IDLE;
      endcase
      if (go_resp) begin
        state_q     <= R_RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= !in_range;
        rsp_rd_q    <= in_range && (cur_op == MEM_READ);
      end
    end
  end

  z8_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RamAw)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (cur_op == MEM_WRITE),
    .addr  (cur_addr[RamAw-1:0]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_z8_mem_responder.sv
// Directed bench: instance A (WAIT_STATES=2, DEPTH=128), instance B (WAIT_STATES=0).
module tb_z8_mem_responder;
  import instruction_set_pkg::*;

  logic       clk;
  logic       rst;
  logic       sel;
  logic       req_valid;
  MEM_OPS_T   req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_ready;

  logic       req_ready_a, rsp_valid_a, rsp_err_a;
  logic       req_ready_b, rsp_valid_b, rsp_err_b;
  logic [7:0] rsp_rdata_a, rsp_rdata_b;
  logic       req_ready_s, rsp_valid_s, rsp_err_s;
  logic [7:0] rsp_rdata_s;

  int n_checks = 0;
  int n_fail   = 0;

  z8_mem_responder #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .DEPTH       (128),
    .WAIT_STATES (2)
  ) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid && !sel),
    .req_ready (req_ready_a),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid_a),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata_a),
    .rsp_err   (rsp_err_a)
  );

  z8_mem_responder #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .DEPTH       (256),
    .WAIT_STATES (0)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid && sel),
    .req_ready (req_ready_b),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid_b),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata_b),
    .rsp_err   (rsp_err_b)
  );

  assign req_ready_s = sel ? req_ready_b : req_ready_a;
  assign rsp_valid_s = sel ? rsp_valid_b : rsp_valid_a;
  assign rsp_err_s   = sel ? rsp_err_b   : rsp_err_a;
  assign rsp_rdata_s = sel ? rsp_rdata_b : rsp_rdata_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of the accept cycle; waits for the response with rsp_ready=1.
  task automatic wait_rsp(input string tag, input int exp_lat, input logic [7:0] exp_rdata,
                          input logic exp_err);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      if (rsp_valid_s) begin
        lat = i;
        break;
      end
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_rdata"}, rsp_rdata_s, exp_rdata);
    check_eq({tag, "_err"}, rsp_err_s, exp_err);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tag, "_ready_after"}, req_ready_s, 1);
    check_eq({tag, "_valid_after"}, rsp_valid_s, 0);
  endtask

  task automatic txn(input string tag, input MEM_OPS_T op, input logic [7:0] addr,
                     input logic [7:0] wdata, input int exp_lat, input logic [7:0] exp_rdata,
                     input logic exp_err);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_accept"}, req_ready_s, 1);
    wait_rsp(tag, exp_lat, exp_rdata, exp_err);
  endtask

  initial begin
    sel       = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = MEM_NOP;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_req_ready", req_ready_a, 1);
    check_eq("rst_rsp_valid", rsp_valid_a, 0);
    check_eq("rst_rsp_rdata", rsp_rdata_a, 0);
    check_eq("rst_rsp_err", rsp_err_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", req_ready_a, 1);

    // Instance A: basic write/read, out-of-range accesses
    txn("wr10", MEM_WRITE, 8'h10, 8'hA5, 3, 8'h00, 1'b0);
    txn("rd10", MEM_READ, 8'h10, 8'h00, 3, 8'hA5, 1'b0);
    txn("wr90", MEM_WRITE, 8'h90, 8'hFF, 3, 8'h00, 1'b1);
    txn("rd90", MEM_READ, 8'h90, 8'h00, 3, 8'h00, 1'b1);
    txn("rd10b", MEM_READ, 8'h10, 8'h00, 3, 8'hA5, 1'b0);
    txn("wr20", MEM_WRITE, 8'h20, 8'h11, 3, 8'h00, 1'b0);
    txn("rd20", MEM_READ, 8'h20, 8'h00, 3, 8'h11, 1'b0);

    // Backpressure: response held 5 cycles, second request waits for the handshake
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = MEM_READ;
    req_addr  = 8'h10;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = MEM_READ;
    req_addr  = 8'h20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid", rsp_valid_a, 1);
      check_eq("bp_rdata", rsp_rdata_a, 8'hA5);
      check_eq("bp_err", rsp_err_a, 0);
      check_eq("bp_req_ready", req_ready_a, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_hs_valid", rsp_valid_a, 1);
    check_eq("bp_hs_req_ready", req_ready_a, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bp_second_accept", req_ready_a, 1);
    check_eq("bp_second_valid", rsp_valid_a, 0);
    wait_rsp("bp_second", 3, 8'h11, 1'b0);

    // Reset during R_WAIT of a write aborts it
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = MEM_WRITE;
    req_addr  = 8'h20;
    req_wdata = 8'h3C;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("rstw_valid", rsp_valid_a, 0);
    check_eq("rstw_req_ready", req_ready_a, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstw_valid_after", rsp_valid_a, 0);
    check_eq("rstw_ready_after", req_ready_a, 1);
    txn("rstw_rd20", MEM_READ, 8'h20, 8'h00, 3, 8'h11, 1'b0);

    // Instance B: zero wait states
    sel = 1'b1;
    txn("b_wr05", MEM_WRITE, 8'h05, 8'h5A, 1, 8'h00, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = MEM_NOP;
    req_addr  = 8'h05;
    req_wdata = 8'hEE;
    @(negedge clk);
    check_eq("b_nop_accept", req_ready_b, 1);
    @(posedge clk); #1;
    req_op = MEM_READ;
    @(negedge clk);
    check_eq("b_nop_no_rsp", rsp_valid_b, 0);
    check_eq("b_rd_accept", req_ready_b, 1);
    wait_rsp("b_rd05", 1, 8'h5A, 1'b0);

    // Undefined opcode behaves as NOP
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = MEM_OPS_T'(2'b11);
    req_addr  = 8'h05;
    req_wdata = 8'h00;
    @(negedge clk);
    check_eq("b_undef_accept", req_ready_b, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("b_undef_no_rsp", rsp_valid_b, 0);
    check_eq("b_undef_idle", req_ready_b, 1);
    txn("b_rd05_after", MEM_READ, 8'h05, 8'h00, 1, 8'h5A, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
